// File: rtl/indirect_array_block.sv
// indirect_array_block
//   Per-channel indirect register arrays behind an APB slave port.
//   Each channel c occupies 0x10*c: INDEX (+0x0: [7:0] idx, [8] ainc),
//   DATA (+0x4: entry[idx]), CTRL (+0x8: [0] lock). +0xC and anything past
//   the last channel are unmapped.
//
//   Optional build macro INDIRECT_ARRAY_BLOCK_WAIT_STATE_EN adds one wait
//   state per access (o_pready from a flop); without it o_pready follows
//   i_psel & i_penable combinationally.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_psel .. i_pstrb     APB request
//   o_pready, o_prdata,
//   o_pslverr             APB response, all zero outside a ready access phase
//   o_entry               every entry, channel c entry e at (c*DEPTH+e)*WIDTH
module indirect_array_block #(
  parameter int          CHANNELS          = 2,
  parameter int          DEPTH             = 4,
  parameter int          WIDTH             = 8,
  parameter int          ERROR_STATUS      = 0,
  parameter logic [31:0] DEFAULT_READ_DATA = 32'h0000_0000
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_psel,
  input  logic                            i_penable,
  input  logic [7:0]                      i_paddr,
  input  logic                            i_pwrite,
  input  logic [31:0]                     i_pwdata,
  input  logic [3:0]                      i_pstrb,
  output logic                            o_pready,
  output logic [31:0]                     o_prdata,
  output logic                            o_pslverr,
  output logic [CHANNELS*DEPTH*WIDTH-1:0] o_entry
);

  localparam logic [8:0] LP_DEPTH  = 9'(DEPTH);
  localparam logic       LP_ERR_EN = (ERROR_STATUS != 0);
  localparam logic [1:0] LP_INDEX  = 2'd0;
  localparam logic [1:0] LP_DATA   = 2'd1;
  localparam logic [1:0] LP_CTRL   = 2'd2;

  logic [7:0]                      r_idx  [CHANNELS];
  logic                            r_ainc [CHANNELS];
  logic                            r_lock [CHANNELS];
  logic [CHANNELS*DEPTH*WIDTH-1:0] r_entry;

  logic                w_ch_ok;
  logic                w_mapped;
  logic [1:0]          w_reg;
  logic [CHANNELS-1:0] w_sel;
  logic [7:0]          w_idx_cur;
  logic                w_ainc_cur;
  logic                w_lock_cur;
  logic [WIDTH-1:0]    w_data_cur;
  logic                w_oob;
  logic                w_err;
  logic                w_xfer;
  logic [31:0]         w_rdata;
  logic [WIDTH-1:0]    w_wmask;
  logic                w_unused;

  // Low address bits and upper data/strobe lanes are don't-care for narrow entries.
  assign w_unused = ^{i_paddr[1:0], i_pwdata, i_pstrb};

`ifdef INDIRECT_ARRAY_BLOCK_WAIT_STATE_EN
  logic r_wait;

  // Set in the first access-phase cycle, drops after completion or when psel goes away.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_wait <= 1'b0;
    else          r_wait <= i_psel & i_penable & ~r_wait;
  end

  assign o_pready = r_wait & i_psel & i_penable;
`else
  // Reset term keeps o_pready low while reset is held, even mid-access.
  assign o_pready = i_psel & i_penable & i_rst_n;
`endif

  assign w_xfer  = i_psel & i_penable & o_pready;
  assign w_reg   = i_paddr[3:2];
  assign w_ch_ok = int'(i_paddr[7:4]) < CHANNELS;
  assign w_mapped = w_ch_ok && (w_reg != 2'd3);

  always_comb begin
    w_sel      = '0;
    w_idx_cur  = '0;
    w_ainc_cur = 1'b0;
    w_lock_cur = 1'b0;
    w_data_cur = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_ch_ok && int'(i_paddr[7:4]) == c) begin
        w_sel[c]   = 1'b1;
        w_idx_cur  = r_idx[c];
        w_ainc_cur = r_ainc[c];
        w_lock_cur = r_lock[c];
        for (int e = 0; e < DEPTH; e++) begin
          if ({1'b0, r_idx[c]} == 9'(e)) w_data_cur = r_entry[(c*DEPTH+e)*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign w_oob = {1'b0, w_idx_cur} >= LP_DEPTH;

  always_comb begin
    for (int b = 0; b < WIDTH; b++) w_wmask[b] = i_pstrb[b/8];
  end

  assign w_err = ~w_mapped | ((w_reg == LP_DATA) & (w_oob | (i_pwrite & w_lock_cur)));

  always_comb begin
    w_rdata = DEFAULT_READ_DATA;
    if (w_mapped) begin
      case (w_reg)
        LP_INDEX: w_rdata = {23'd0, w_ainc_cur, w_idx_cur};
        LP_DATA:  w_rdata = w_oob ? 32'd0 : 32'(w_data_cur);
        LP_CTRL:  w_rdata = {31'd0, w_lock_cur};
        default:  w_rdata = DEFAULT_READ_DATA;
      endcase
    end
  end

  assign o_prdata  = w_xfer ? w_rdata : 32'd0;
  assign o_pslverr = w_xfer & LP_ERR_EN & w_err;
  assign o_entry   = r_entry;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_idx[c]  <= '0;
        r_ainc[c] <= 1'b0;
        r_lock[c] <= 1'b0;
      end
      r_entry <= '0;
    end else if (w_xfer && w_mapped) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_sel[c]) begin
          if (i_pwrite && w_reg == LP_INDEX) begin
            if (i_pstrb[0]) r_idx[c]  <= i_pwdata[7:0];
            if (i_pstrb[1]) r_ainc[c] <= i_pwdata[8];
          end
          if (i_pwrite && w_reg == LP_CTRL && i_pstrb[0]) r_lock[c] <= i_pwdata[0];
          if (w_reg == LP_DATA && !w_oob) begin
            // Auto-increment applies to reads and to writes blocked by lock.
            if (r_ainc[c]) begin
              if ({1'b0, r_idx[c]} == LP_DEPTH - 9'd1) r_idx[c] <= '0;
              else                                    r_idx[c] <= r_idx[c] + 8'd1;
            end
            if (i_pwrite && !r_lock[c]) begin
              for (int e = 0; e < DEPTH; e++) begin
                if ({1'b0, r_idx[c]} == 9'(e)) begin
                  for (int b = 0; b < WIDTH; b++) begin
                    if (w_wmask[b]) r_entry[(c*DEPTH+e)*WIDTH+b] <= i_pwdata[b];
                  end
                end
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_indirect_array_block.sv
module tb_indirect_array_block;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        o_pready;
  logic [31:0] o_prdata;
  logic        o_pslverr;
  logic [63:0] o_entry;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd;
  logic        err;
  int          waits;

`ifdef INDIRECT_ARRAY_BLOCK_WAIT_STATE_EN
  localparam int EXP_WAITS = 1;
`else
  localparam int EXP_WAITS = 0;
`endif

  indirect_array_block #(
    .CHANNELS(2), .DEPTH(4), .WIDTH(8), .ERROR_STATUS(1),
    .DEFAULT_READ_DATA(32'hDEAD_BEEF)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_psel(psel), .i_penable(penable),
    .i_paddr(paddr), .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_pready(o_pready), .o_prdata(o_prdata), .o_pslverr(o_pslverr),
    .o_entry(o_entry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] s);
    int n;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(negedge clk);
    penable = 1'b1;
    #1;
    n = 0;
    while (o_pready !== 1'b1 && n < 4) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("pready_seen", {63'd0, o_pready}, 64'd1);
    rd    = o_prdata;
    err   = o_pslverr;
    waits = n;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr32(input logic [7:0] a, input logic [31:0] d);
    apb(1'b1, a, d, 4'hF);
  endtask

  task automatic rd32(input logic [7:0] a);
    apb(1'b0, a, 32'd0, 4'h0);
  endtask

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (2) @(negedge clk);
    check("rst_pready", {63'd0, o_pready}, 64'd0);
    check("rst_prdata", {32'd0, o_prdata}, 64'd0);
    check("rst_pslverr", {63'd0, o_pslverr}, 64'd0);
    check("rst_entry", o_entry, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Auto-increment with wrap on channel 0
    wr32(8'h00, 32'h100);
    wr32(8'h04, 32'h11);
    wr32(8'h04, 32'h22);
    wr32(8'h04, 32'h33);
    wr32(8'h04, 32'h44);
    wr32(8'h04, 32'h55);
    check("ainc_wr_err", {63'd0, err}, 64'd0);
    @(negedge clk);
    check("ainc_entries", o_entry, 64'h0000_0000_4433_2255);
    rd32(8'h00);
    check("ainc_idx", {32'd0, rd}, 64'h101);

    // Channel 1 isolated access
    wr32(8'h10, 32'h002);
    wr32(8'h14, 32'hAB);
    rd32(8'h14);
    check("ch1_read", {32'd0, rd}, 64'hAB);
    check("ch1_entries", o_entry, 64'h00AB_0000_4433_2255);

    // Zero strobes leave the entry untouched
    apb(1'b1, 8'h14, 32'hCD, 4'h0);
    @(negedge clk);
    check("strb0_entry", o_entry, 64'h00AB_0000_4433_2255);

    // Out-of-range index
    wr32(8'h00, 32'h107);
    wr32(8'h04, 32'hFF);
    check("oob_wr_err", {63'd0, err}, 64'd1);
    @(negedge clk);
    check("oob_entries", o_entry, 64'h00AB_0000_4433_2255);
    rd32(8'h00);
    check("oob_idx_after_wr", {32'd0, rd}, 64'h107);
    check("oob_idx_rd_err", {63'd0, err}, 64'd0);
    rd32(8'h04);
    check("oob_rd_data", {32'd0, rd}, 64'd0);
    check("oob_rd_err", {63'd0, err}, 64'd1);
    rd32(8'h00);
    check("oob_idx_after_rd", {32'd0, rd}, 64'h107);

    // Lock
    wr32(8'h08, 32'h1);
    wr32(8'h00, 32'h100);
    wr32(8'h04, 32'h99);
    check("lock_wr_err", {63'd0, err}, 64'd1);
    @(negedge clk);
    check("lock_entries", o_entry, 64'h00AB_0000_4433_2255);
    rd32(8'h00);
    check("lock_idx", {32'd0, rd}, 64'h101);
    rd32(8'h08);
    check("lock_ctrl", {32'd0, rd}, 64'h1);
    rd32(8'h04);
    check("lock_rd_data", {32'd0, rd}, 64'h22);
    check("lock_rd_err", {63'd0, err}, 64'd0);
    wr32(8'h08, 32'h0);
    wr32(8'h00, 32'h100);
    wr32(8'h04, 32'h99);
    check("unlock_wr_err", {63'd0, err}, 64'd0);
    @(negedge clk);
    check("unlock_entries", o_entry, 64'h00AB_0000_4433_2299);

    // Unmapped addresses
    rd32(8'h3C);
    check("unmap_rd", {32'd0, rd}, 64'hDEAD_BEEF);
    check("unmap_err", {63'd0, err}, 64'd1);
    check("unmap_waits", 64'(waits), 64'(EXP_WAITS));
    #1;
    check("idle_prdata", {32'd0, o_prdata}, 64'd0);
    check("idle_pslverr", {63'd0, o_pslverr}, 64'd0);
    rd32(8'h0C);
    check("hole_rd", {32'd0, rd}, 64'hDEAD_BEEF);
    check("hole_err", {63'd0, err}, 64'd1);
    wr32(8'h20, 32'hFFFF_FFFF);
    check("unmap_wr_err", {63'd0, err}, 64'd1);
    @(negedge clk);
    check("unmap_wr_entries", o_entry, 64'h00AB_0000_4433_2299);

    // Setup phase drives no response
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h3C;
    #1;
    check("setup_pready", {63'd0, o_pready}, 64'd0);
    check("setup_prdata", {32'd0, o_prdata}, 64'd0);
    @(negedge clk);
    psel = 1'b0;

    // Reset during a DATA write access phase
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04;
    pwdata = 32'h77; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_pready", {63'd0, o_pready}, 64'd0);
    check("midrst_prdata", {32'd0, o_prdata}, 64'd0);
    check("midrst_pslverr", {63'd0, o_pslverr}, 64'd0);
    check("midrst_entry", o_entry, 64'd0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_entry", o_entry, 64'd0);
    rd32(8'h00);
    check("postrst_idx", {32'd0, rd}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/indirect_array_block.md
INDIRECT_ARRAY_BLOCK -- requirements
Module: indirect_array_block

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent indirect arrays, legal 1..8.
REQ-002 SHALL have parameter DEPTH, default 4: entries per channel, legal 2..256.
REQ-003 SHALL have parameter WIDTH, default 8: bits per entry, legal 1..32.
REQ-004 SHALL have parameter ERROR_STATUS, default 0: 1 enables o_pslverr reporting.
REQ-005 SHALL have parameter DEFAULT_READ_DATA, default 32'h00000000: read data for unmapped addresses.
REQ-006 SHALL have port i_clk  input  1  sole clock; all flops rise-edge.
REQ-007 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port i_psel  input  1  APB select.
REQ-009 SHALL have port i_penable  input  1  APB enable.
REQ-010 SHALL have port i_paddr  input  8  APB byte address.
REQ-011 SHALL have port i_pwrite  input  1  APB write flag.
REQ-012 SHALL have port i_pwdata  input  32  APB write data.
REQ-013 SHALL have port i_pstrb  input  4  APB byte strobes.
REQ-014 SHALL have port o_pready  output  1  APB ready.
REQ-015 SHALL have port o_prdata  output  32  APB read data.
REQ-016 SHALL have port o_pslverr  output  1  APB error.
REQ-017 SHALL have port o_entry  output  CHANNELS*DEPTH*WIDTH  all entries, channel c entry e at bit offset (c*DEPTH+e)*WIDTH.

Function
REQ-018 Per channel c, base 0x10*c: INDEX at +0x0 (bits[7:0] idx, bit8 ainc), DATA at +0x4, CTRL at +0x8 (bit0 lock); +0xC and addresses >= 0x10*CHANNELS unmapped.
REQ-019 Access completes on the rising edge where i_psel & i_penable & o_pready; register state changes only on that edge.
REQ-020 DATA read returns entry[idx] zero-extended to 32 bits; DATA write updates entry[idx] only in byte lanes with i_pstrb set.
REQ-021 After a completed DATA access (read or write) with ainc=1 and idx<DEPTH, idx becomes idx+1, wrapping DEPTH-1 -> 0.
REQ-022 idx >= DEPTH: DATA read returns 0, write dropped, idx not incremented, o_pslverr=ERROR_STATUS.
REQ-023 lock=1: DATA writes dropped, o_pslverr=ERROR_STATUS, ainc still increments idx; DATA reads unaffected; INDEX/CTRL remain writable.
REQ-024 INDEX/CTRL write byte lanes per i_pstrb; unused bits read 0; INDEX write stores all 8 idx bits even if >= DEPTH.
REQ-025 Unmapped read returns DEFAULT_READ_DATA, write ignored, o_pslverr=ERROR_STATUS.
REQ-026 o_prdata and o_pslverr SHALL be 0 whenever o_pready is 0 or no access phase is active.
REQ-027 o_entry SHALL reflect new entry value the cycle after the completing edge.
REQ-028 Channels fully independent; an access touches only the addressed channel.

Reset
REQ-029 Asserting i_rst_n low SHALL immediately clear all entries, idx, ainc, lock, the wait-state flop, and force o_pready=0, o_prdata=0, o_pslverr=0.
REQ-030 Reset asserted mid-access SHALL abort it with no state update; after release the bus master restarts from setup phase.

Configuration
REQ-031 Macro INDIRECT_ARRAY_BLOCK_WAIT_STATE_EN defined: o_pready low in the first access-phase cycle, high in the second (one wait state, registered response); flop clears when i_psel drops.
REQ-032 Macro undefined: o_pready = i_psel & i_penable combinationally (zero wait states); no wait-state flop present.

Verification
REQ-033 CHANNELS=2,DEPTH=4,WIDTH=8: write INDEX ch0=0x100, write DATA 0x11,0x22,0x33,0x44,0x55 -> entries 0x55,0x22,0x33,0x44, idx reads 0x101.
REQ-034 ch1 INDEX=0x002, write DATA 0xAB, read DATA -> 0xAB, o_entry[(1*4+2)*8+:8]=0xAB, ch0 unchanged.
REQ-035 ERROR_STATUS=1, ch0 INDEX=0x007, write DATA 0xFF -> o_pslverr=1, no entry changes, idx stays 7; read -> 0x00, pslverr=1.
REQ-036 ch0 CTRL=1, INDEX=0x100, write DATA 0x99 -> pslverr=1 (ERROR_STATUS=1), entry[0] unchanged, idx=1; CTRL=0 then write succeeds.
REQ-037 Read 0x3C (unmapped, CHANNELS=2) with DEFAULT_READ_DATA=0xDEADBEEF -> 0xDEADBEEF; with macro defined o_pready low 1 cycle then high, else high in first access cycle.
REQ-038 Drop i_rst_n during DATA write access phase -> all outputs 0 immediately, entries 0 after release.
